serial_add_sub: RTL and testbench

- Multi-cycle adder/subtractor. Processes DIGIT bits per clock, LSB first, with a registered carry/borrow between digits.
- Parametrised successor to the team's combinational half/full subtractor cells. Adds a selectable add/sub mode, a start/busy/done handshake, a carry/borrow output and a signed-overflow flag.
- Used in datapaths where area matters more than latency.

---
 rtl/serial_add_sub.sv | 133 +++++++++++++
 tb/tb_serial_add_sub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with a registered
// carry/borrow between digits and a start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode;
    logic             r_cy;
    logic             r_sa;
    logic             r_sb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cb;
    logic             r_ovf;

    logic [DIGIT-1:0] w_ad;
    logic [DIGIT-1:0] w_bd;
    logic [DIGIT:0]   w_dig;
    logic [WIDTH-1:0] w_s_ext;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_cout;
    logic             w_ovf;
    logic             w_accept;
    logic             w_last;

    always_comb begin
        w_ad = r_a[DIGIT-1:0];
        w_bd = r_b[DIGIT-1:0];
        // A negative digit difference wraps into bit DIGIT, which is exactly the borrow out.
        if (r_mode) begin
            w_dig = {1'b0, w_ad} - {1'b0, w_bd} - {{DIGIT{1'b0}}, r_cy};
        end else begin
            w_dig = {1'b0, w_ad} + {1'b0, w_bd} + {{DIGIT{1'b0}}, r_cy};
        end
        w_cout  = w_dig[DIGIT];
        w_s_ext = '0;
        w_s_ext[DIGIT-1:0] = w_dig[DIGIT-1:0];
        w_acc_next = (r_acc >> DIGIT) | (w_s_ext << (WIDTH - DIGIT));
        if (r_mode) begin
            w_ovf = (r_sa != r_sb) && (w_acc_next[WIDTH-1] != r_sa);
        end else begin
            w_ovf = (r_sa == r_sb) && (w_acc_next[WIDTH-1] != r_sa);
        end
    end

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mode   <= 1'b0;
            r_cy     <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cb     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_acc <= w_acc_next;
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_result <= w_acc_next;
                        r_cb     <= w_cout;
                        r_ovf    <= w_ovf;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= b[WIDTH-1];
                        r_cy    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy         = (r_state == S_RUN);
    assign done         = (r_state == S_DONE);
    assign result       = r_result;
    assign carry_borrow = r_cb;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: five instances covering 8-bit and 4-bit widths with several digit sizes.
module tb_serial_add_sub;

    localparam int NI = 5;
    localparam int WS[NI] = '{8, 8, 4, 4, 4};
    localparam int DS[NI] = '{1, 4, 1, 2, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] v_start;
    logic [NI-1:0] v_mode;
    logic [7:0]    v_a [NI];
    logic [7:0]    v_b [NI];
    wire  [NI-1:0] v_busy;
    wire  [NI-1:0] v_done;
    wire  [NI-1:0] v_cb;
    wire  [NI-1:0] v_ov;
    wire  [7:0]    v_res [NI];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WS[g]-1:0] w_res;
        serial_add_sub #(.WIDTH(WS[g]), .DIGIT(DS[g])) u_dut (
            .clk(clk), .rst(rst), .start(v_start[g]), .mode(v_mode[g]),
            .a(v_a[g][WS[g]-1:0]), .b(v_b[g][WS[g]-1:0]),
            .busy(v_busy[g]), .done(v_done[g]), .result(w_res),
            .carry_borrow(v_cb[g]), .overflow(v_ov[g])
        );
        assign v_res[g] = 8'(w_res);
    end

    typedef struct {
        int         k;
        bit         m;
        logic [7:0] a;
        logic [7:0] b;
        int         res;
        int         cb;
        int         ov;
        int         lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference: whole-word integer arithmetic with signed range test for overflow.
    function automatic void model(input int w, input bit m, input int a, input int b,
                                  output int res, output int cb, output int ov);
        int md, full, sa, sb, s;
        md   = 1 << w;
        full = m ? a - b : a + b;
        res  = full & (md - 1);
        cb   = m ? int'(a < b) : int'(full >= md);
        sa   = (a >= md / 2) ? a - md : a;
        sb   = (b >= md / 2) ? b - md : b;
        s    = m ? sa - sb : sa + sb;
        ov   = int'(s < -(md / 2) || s >= md / 2);
    endfunction

    task automatic run_op(input int k, input bit m, input logic [7:0] av, input logic [7:0] bv,
                          output int res, output int cb, output int ov, output int lat, output int bcnt);
        @(negedge clk);
        v_a[k] = av; v_b[k] = bv; v_mode[k] = m; v_start[k] = 1'b1;
        @(posedge clk); #1;
        v_start[k] = 1'b0;
        v_a[k] = ~av; v_b[k] = ~bv; v_mode[k] = ~m;
        lat = 1; bcnt = 0;
        while (!v_done[k] && lat < 40) begin
            if (v_busy[k]) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = int'(v_res[k]); cb = int'(v_cb[k]); ov = int'(v_ov[k]);
    endtask

    initial begin
        vec_t vt[7];
        int res, cb, ov, lat, bcnt, k, er, ec, eo, seen, hold_ok;
        bit m;
        logic [7:0] ra, rb;

        v_start = '0; v_mode = '0;
        for (int i = 0; i < NI; i++) begin v_a[i] = '0; v_b[i] = '0; end

        vt[0] = '{0, 1'b1, 8'h05, 8'h03, 'h02, 0, 0, 9};
        vt[1] = '{0, 1'b1, 8'h03, 8'h05, 'hFE, 1, 0, 9};
        vt[2] = '{0, 1'b1, 8'h80, 8'h01, 'h7F, 0, 1, 9};
        vt[3] = '{1, 1'b0, 8'hFF, 8'h01, 'h00, 1, 0, 3};
        vt[4] = '{1, 1'b0, 8'h7F, 8'h01, 'h80, 0, 1, 3};
        vt[5] = '{1, 1'b1, 8'h10, 8'h20, 'hF0, 1, 0, 3};
        vt[6] = '{0, 1'b0, 8'hC8, 8'h64, 'h2C, 1, 0, 9};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_outputs", int'({v_busy[i], v_done[i], v_cb[i], v_ov[i]}), 0);
            check("reset_result", int'(v_res[i]), 0);
        end
        @(negedge clk); rst = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].k, vt[i].m, vt[i].a, vt[i].b, res, cb, ov, lat, bcnt);
            check("vec_result", res, vt[i].res);
            check("vec_carry_borrow", cb, vt[i].cb);
            check("vec_overflow", ov, vt[i].ov);
            check("vec_latency", lat, vt[i].lat);
            check("vec_busy_cycles", bcnt, vt[i].lat - 1);
        end
        @(posedge clk); #1;
        check("done_single_cycle", int'(v_done[0]), 0);

        // start pulsed mid-run is ignored; start held through DONE chains a second op.
        @(negedge clk);
        v_a[0] = 8'h12; v_b[0] = 8'h34; v_mode[0] = 1'b0; v_start[0] = 1'b1;
        @(posedge clk); #1;
        v_start[0] = 1'b0; v_a[0] = 8'hFF; v_b[0] = 8'hFF;
        lat = 1;
        while (lat < 3) begin @(posedge clk); #1; lat++; end
        v_start[0] = 1'b1; v_mode[0] = 1'b1; v_a[0] = 8'h99; v_b[0] = 8'h01;
        @(posedge clk); #1; lat++;
        v_start[0] = 1'b0;
        while (!v_done[0] && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ignore_start_latency", lat, 9);
        check("ignore_start_result", int'(v_res[0]), 'h46);
        check("ignore_start_cb", int'(v_cb[0]), 0);
        v_a[0] = 8'h50; v_b[0] = 8'h70; v_mode[0] = 1'b1; v_start[0] = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy", int'(v_busy[0]), 1);
        lat = 1; hold_ok = 1;
        while (!v_done[0] && lat < 40) begin
            if (v_res[0] != 8'h46) hold_ok = 0;
            @(posedge clk); #1; lat++;
        end
        v_start[0] = 1'b0;
        check("b2b_hold_prev", hold_ok, 1);
        check("b2b_latency", lat, 9);
        check("b2b_result", int'(v_res[0]), 'hE0);
        check("b2b_borrow", int'(v_cb[0]), 1);
        check("b2b_overflow", int'(v_ov[0]), 0);
        @(posedge clk); #1;
        check("b2b_done_pulse", int'(v_done[0]), 0);

        // Asynchronous reset in the middle of RUN cycle 4.
        @(negedge clk);
        v_a[0] = 8'h11; v_b[0] = 8'h22; v_mode[0] = 1'b0; v_start[0] = 1'b1;
        @(posedge clk); #1;
        v_start[0] = 1'b0;
        lat = 1;
        while (lat < 4) begin @(posedge clk); #1; lat++; end
        #2; rst = 1'b1; #1;
        check("async_rst_busy", int'(v_busy[0]), 0);
        check("async_rst_done", int'(v_done[0]), 0);
        check("async_rst_result", int'(v_res[0]), 0);
        check("async_rst_flags", int'({v_cb[0], v_ov[0]}), 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (v_done[0]) seen++; end
        check("rst_no_done", seen, 0);
        run_op(0, 1'b1, 8'h10, 8'h20, res, cb, ov, lat, bcnt);
        check("post_rst_result", res, 'hF0);
        check("post_rst_borrow", cb, 1);
        check("post_rst_overflow", ov, 0);
        check("post_rst_latency", lat, 9);

        for (int i = 0; i < 100; i++) begin
            k  = int'($urandom_range(0, 1));
            m  = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            model(8, m, int'(ra), int'(rb), er, ec, eo);
            run_op(k, m, ra, rb, res, cb, ov, lat, bcnt);
            check("rand_result", res, er);
            check("rand_carry_borrow", cb, ec);
            check("rand_overflow", ov, eo);
            check("rand_latency", lat, WS[k] / DS[k] + 1);
        end

        for (int kk = 2; kk < NI; kk++) begin
            for (int mi = 0; mi < 2; mi++) begin
                for (int ai = 0; ai < 16; ai++) begin
                    for (int bi = 0; bi < 16; bi++) begin
                        model(4, mi[0], ai, bi, er, ec, eo);
                        run_op(kk, mi[0], 8'(ai), 8'(bi), res, cb, ov, lat, bcnt);
                        check("exh_result", res, er);
                        check("exh_carry_borrow", cb, ec);
                        check("exh_overflow", ov, eo);
                        check("exh_latency", lat, WS[kk] / DS[kk] + 1);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
